// File: rtl/i2c_pkg.sv
// Shared widths, timeout default and FSM encoding for the two-requester I2C arbiter.
package i2c_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_REGISTER_WIDTH = 16;
  localparam int DEF_ADDRESS_WIDTH  = 15;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_RUN       = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q, last_d;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt    = (en && |req) ? idx_to_onehot(gnt_idx) : 2'b00;
    last_d = (en && |req) ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between two requesters; per-state timeout aborts a hung master.
//   state     | meaning
//   IDLE      | grant a requester, latch its request
//   WAIT_BUSY | enable high, waiting for master busy
//   RUN       | master busy, waiting for it to finish
//   RESP      | one-cycle rsp_valid pulse to the owner
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_rw,
  input  logic [2*REGISTER_WIDTH-1:0] req_reg_addr,
  input  logic [2*ADDRESS_WIDTH-1:0]  req_dev_addr,
  input  logic [2*DATA_WIDTH-1:0]     req_wdata,
  output logic [1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_error,
  output logic                        m_enable,
  output logic                        m_read_write,
  output logic [DATA_WIDTH-1:0]       m_mosi_data,
  output logic [REGISTER_WIDTH-1:0]   m_register_address,
  output logic [ADDRESS_WIDTH-1:0]    m_device_address,
  input  logic [DATA_WIDTH-1:0]       m_miso_data,
  input  logic                        m_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      rw_q, rw_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REGISTER_WIDTH-1:0] reg_q, reg_d;
  logic [ADDRESS_WIDTH-1:0]  dev_q, dev_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [1:0]                gnt;
  logic                      gnt_idx;
  logic                      timeout;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == ST_IDLE),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Timeout takes priority so a busy edge arriving on the terminal cycle still aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (|gnt) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (timeout) state_d = ST_RESP;
                    else if (m_busy) state_d = ST_RUN;
      ST_RUN:       if (timeout || !m_busy) state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready          = gnt;
    m_enable           = (state_q == ST_WAIT_BUSY);
    rsp_valid          = (state_q == ST_RESP) ? idx_to_onehot(owner_q) : 2'b00;
    rsp_error          = err_q;
    rsp_rdata          = rdata_q;
    m_read_write       = rw_q;
    m_mosi_data        = wdata_q;
    m_register_address = reg_q;
    m_device_address   = dev_q;
  end

  always_comb begin
    owner_d = owner_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    reg_d   = reg_q;
    dev_d   = dev_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == ST_IDLE && |gnt) begin
      owner_d = gnt_idx;
      rw_d    = gnt_idx ? req_rw[1] : req_rw[0];
      wdata_d = gnt_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
      reg_d   = gnt_idx ? req_reg_addr[REGISTER_WIDTH +: REGISTER_WIDTH]
                        : req_reg_addr[0 +: REGISTER_WIDTH];
      dev_d   = gnt_idx ? req_dev_addr[ADDRESS_WIDTH +: ADDRESS_WIDTH]
                        : req_dev_addr[0 +: ADDRESS_WIDTH];
    end
    if ((state_q == ST_WAIT_BUSY || state_q == ST_RUN) && state_d == ST_RESP) begin
      err_d   = timeout;
      rdata_d = (!timeout && rw_q) ? m_miso_data : '0;
    end
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == ST_WAIT_BUSY || state_q == ST_RUN)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      reg_q   <= '0;
      dev_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      reg_q   <= reg_d;
      dev_q   <= dev_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: grants, round-robin order, timeout abort and mid-transaction reset.
module tb_i2c_arbiter;

  localparam int DW = 16;
  localparam int RW = 16;
  localparam int AW = 15;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_rw = '0;
  logic [2*RW-1:0] req_reg_addr = '0;
  logic [2*AW-1:0] req_dev_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic            m_enable;
  logic            m_read_write;
  logic [DW-1:0]   m_mosi_data;
  logic [RW-1:0]   m_register_address;
  logic [AW-1:0]   m_device_address;
  logic [DW-1:0]   m_miso_data = '0;
  logic            m_busy = 1'b0;

  int total = 0;
  int bad   = 0;

  i2c_arbiter #(
    .DATA_WIDTH     (DW),
    .REGISTER_WIDTH (RW),
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_rw             (req_rw),
    .req_reg_addr       (req_reg_addr),
    .req_dev_addr       (req_dev_addr),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_error          (rsp_error),
    .m_enable           (m_enable),
    .m_read_write       (m_read_write),
    .m_mosi_data        (m_mosi_data),
    .m_register_address (m_register_address),
    .m_device_address   (m_device_address),
    .m_miso_data        (m_miso_data),
    .m_busy             (m_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Simple master: busy rises one cycle after enable, stays high len cycles.
  task automatic master(input int len, input logic [15:0] miso);
    for (int i = 0; i < 40 && m_enable !== 1'b1; i++) step();
    chk("enable_seen", m_enable, 1);
    step();
    m_busy = 1'b1;
    repeat (len) step();
    m_miso_data = miso;
    m_busy = 1'b0;
    for (int i = 0; i < 40 && rsp_valid === 2'b00; i++) step();
    chk("rsp_seen", |rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [1:0]  exp_rdy [4];
  logic [15:0] exp_wd  [4];

  initial begin
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_wd  = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};

    repeat (3) step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_enable", m_enable, 0);
    chk("rst_error", rsp_error, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_dev", m_device_address, 0);
    reset = 1'b1;
    step();

    // Req0 write, busy high 10 cycles, valid dropped right after grant
    req_valid    = 2'b01;
    req_rw       = 2'b00;
    req_reg_addr = {16'h0000, 16'h0010};
    req_dev_addr = {15'h0000, 15'h0001};
    req_wdata    = {16'h0000, 16'hBEEF};
    #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_en_idle", m_enable, 0);
    step();
    req_valid = 2'b00;
    chk("t1_en", m_enable, 1);
    chk("t1_ready_wait", req_ready, 0);
    chk("t1_rw", m_read_write, 0);
    chk("t1_wdata", m_mosi_data, 16'hBEEF);
    chk("t1_reg", m_register_address, 16'h0010);
    chk("t1_dev", m_device_address, 15'h0001);
    step();
    chk("t1_en2", m_enable, 1);
    m_busy = 1'b1;
    repeat (10) step();
    chk("t1_en_run", m_enable, 0);
    chk("t1_no_rsp", rsp_valid, 0);
    m_miso_data = 16'hFFFF;
    m_busy = 1'b0;
    step();
    chk("t1_rsp", rsp_valid, 2'b01);
    chk("t1_err", rsp_error, 0);
    chk("t1_rdata", rsp_rdata, 0);
    chk("t1_mosi_hold", m_mosi_data, 16'hBEEF);
    step();
    chk("t1_pulse", rsp_valid, 0);

    // Req1 read with busy already high in IDLE
    m_busy       = 1'b1;
    req_valid    = 2'b10;
    req_rw       = 2'b10;
    req_reg_addr = {16'h0002, 16'h0000};
    req_dev_addr = {15'h0050, 15'h0000};
    #1;
    chk("t2_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("t2_en", m_enable, 1);
    chk("t2_rw", m_read_write, 1);
    chk("t2_reg", m_register_address, 16'h0002);
    chk("t2_dev", m_device_address, 15'h0050);
    step();
    chk("t2_run_en", m_enable, 0);
    step();
    step();
    m_miso_data = 16'hA55A;
    m_busy = 1'b0;
    step();
    chk("t2_rsp", rsp_valid, 2'b10);
    chk("t2_rdata", rsp_rdata, 16'hA55A);
    chk("t2_err", rsp_error, 0);
    step();

    // Both requesting continuously: order 0,1,0,1
    req_valid    = 2'b11;
    req_rw       = 2'b00;
    req_reg_addr = {16'h0040, 16'h0030};
    req_dev_addr = {15'h0004, 15'h0003};
    req_wdata    = {16'h2222, 16'h1111};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ready", req_ready, exp_rdy[i]);
      step();
      chk("t3_ready_busy", req_ready, 0);
      chk("t3_mosi", m_mosi_data, exp_wd[i]);
      master(2, 16'hFFFF);
      chk("t3_rsp", rsp_valid, exp_rdy[i]);
      chk("t3_rdata", rsp_rdata, 0);
      if (i == 3) req_valid = 2'b00;
      step();
    end

    // Timeout: busy never rises
    m_miso_data = 16'hFFFF;
    req_valid   = 2'b01;
    req_rw      = 2'b01;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    repeat (15) step();
    chk("t4_before", rsp_valid, 0);
    chk("t4_en_wait", m_enable, 1);
    step();
    chk("t4_rsp", rsp_valid, 2'b01);
    chk("t4_err", rsp_error, 1);
    chk("t4_rdata", rsp_rdata, 0);
    chk("t4_en_off", m_enable, 0);
    step();
    chk("t4_pulse", rsp_valid, 0);

    // Reset during RUN, then req1 alone is granted normally
    req_valid    = 2'b10;
    req_rw       = 2'b10;
    req_reg_addr = {16'h0077, 16'h0000};
    req_dev_addr = {15'h0011, 15'h0000};
    req_wdata    = {16'h3333, 16'h0000};
    #1;
    chk("t6_ready_pre", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    m_busy = 1'b1;
    step();
    chk("t6_run", m_enable, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_rsp", rsp_valid, 0);
    chk("t6_rst_en", m_enable, 0);
    chk("t6_rst_err", rsp_error, 0);
    chk("t6_rst_rdata", rsp_rdata, 0);
    chk("t6_rst_rw", m_read_write, 0);
    chk("t6_rst_mosi", m_mosi_data, 0);
    chk("t6_rst_reg", m_register_address, 0);
    chk("t6_rst_dev", m_device_address, 0);
    m_busy = 1'b0;
    repeat (3) step();
    chk("t6_rst_norsp", rsp_valid, 0);
    reset = 1'b1;
    step();
    req_valid = 2'b10;
    #1;
    chk("t6_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("t6_reg", m_register_address, 16'h0077);
    master(3, 16'h0F0F);
    chk("t6_rsp", rsp_valid, 2'b10);
    chk("t6_rdata", rsp_rdata, 16'h0F0F);
    chk("t6_err", rsp_error, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of write and read data.
REQ-002 Parameter REGISTER_WIDTH, default 16, width of the register address.
REQ-003 Parameter ADDRESS_WIDTH, default 15, width of the device address.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000, clk cycles allowed per wait state before abort.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  2  per-requester transaction request (bit i = requester i).
REQ-008 req_ready  output  2  per-requester accept, one-hot or zero.
REQ-009 req_rw  input  2  per-requester direction, 1 = read, 0 = write.
REQ-010 req_reg_addr  input  2*REGISTER_WIDTH  requester i in slice [i*RW +: RW].
REQ-011 req_dev_addr  input  2*ADDRESS_WIDTH  requester i in slice [i*AW +: AW].
REQ-012 req_wdata  input  2*DATA_WIDTH  requester i in slice [i*DW +: DW].
REQ-013 rsp_valid  output  2  one-cycle completion pulse, one-hot.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid.
REQ-015 rsp_error  output  1  timeout flag, valid with rsp_valid.
REQ-016 m_enable  output  1  to master enable.
REQ-017 m_read_write  output  1  to master read_write.
REQ-018 m_mosi_data  output  DATA_WIDTH  to master mosi_data.
REQ-019 m_register_address  output  REGISTER_WIDTH  to master register_address.
REQ-020 m_device_address  output  ADDRESS_WIDTH  to master device_address.
REQ-021 m_miso_data  input  DATA_WIDTH  from master miso_data.
REQ-022 m_busy  input  1  from master busy.

Function
REQ-023 FSM states: IDLE, WAIT_BUSY, RUN, RESP; exactly one active.
REQ-024 IDLE: if any req_valid, grant g per round-robin; req_ready[g]=1 combinationally that cycle; latch rw/addresses/wdata of g on that edge; next state WAIT_BUSY.
REQ-025 Round-robin: single requester valid -> it wins; both valid -> requester != last_grant wins; last_grant updated on grant.
REQ-026 req_ready SHALL be 0 in every state other than IDLE.
REQ-027 m_read_write, m_mosi_data, m_register_address, m_device_address SHALL be driven from latched fields, stable from grant until the following IDLE.
REQ-028 WAIT_BUSY: m_enable=1; on m_busy=1 -> RUN (m_enable=0 from the next cycle).
REQ-029 RUN: m_enable=0; on m_busy=0 -> capture m_miso_data if read (0 if write) into rsp_rdata; -> RESP.
REQ-030 RESP: rsp_valid[g]=1 for exactly one cycle, rsp_error held; -> IDLE; new grant possible in the cycle after RESP.
REQ-031 Timeout counter clears on every state entry, counts in WAIT_BUSY and RUN; reaching TIMEOUT_CYCLES-1 -> RESP with rsp_error=1, rsp_rdata=0, m_enable=0.
REQ-032 Counter width = clog2(TIMEOUT_CYCLES); no wrap occurs before the terminal compare.
REQ-033 Minimum transaction: grant -> rsp_valid = 3 cycles + master busy duration.
REQ-034 req_valid deassertion after grant has no effect on the transaction in flight.
REQ-035 m_busy=1 observed while in IDLE SHALL be ignored (no grant suppression, no error).

Reset
REQ-036 reset low SHALL asynchronously force IDLE; m_enable, req_ready, rsp_valid, rsp_error, rsp_rdata, latched fields and counter to 0; last_grant to 1 (requester 0 wins first).
REQ-037 Reset mid-transaction SHALL drop it with no rsp_valid; release resumes from IDLE.

Structure
REQ-038 Package i2c_pkg SHALL hold default widths (16/16/15), the FSM state encoding and TIMEOUT_CYCLES default.
REQ-039 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and last_grant register.

Verification
REQ-040 Req0 write, reg 0x0010, dev 0x0001, wdata 0xBEEF; busy high 10 cycles -> req_ready=01, m_enable high until busy, rsp_valid=01, rsp_error=0, rdata 0x0000.
REQ-041 Req1 read reg 0x0002; master returns 0xA55A -> rsp_valid=10, rsp_rdata=0xA55A.
REQ-042 Both valid continuously, 4 transactions -> grant order 0,1,0,1.
REQ-043 TIMEOUT_CYCLES=16, busy never rises -> rsp_error=1 16 cycles after WAIT_BUSY entry, m_enable=0.
REQ-044 Reset asserted during RUN -> all outputs 0 immediately, no rsp_valid; next request from req1 only is granted normally.
REQ-045 Req0 drops valid the cycle after grant -> transaction completes, rsp_valid=01.
